// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types for the multiply/divide unit.
//   mdu_op_e    - RISC-V M-extension funct3 encodings
//   mdu_state_e - sequencer FSM states
//   MDU_XLEN_DEFAULT - default operand/result width
package mdu_pkg;

  localparam int MDU_XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_datapath.sv
// mdu_datapath: iterative unsigned shift-add multiplier / restoring divider.
// Ports:
//   clk    - clock
//   load   - capture a_in/b_in and clear the accumulator
//   step   - perform one multiply or divide iteration
//   is_div - select restoring-subtract (1) or shift-add (0) step
//   a_in   - multiplier / dividend magnitude
//   b_in   - multiplicand / divisor magnitude
//   hi     - product high half / remainder
//   lo     - product low half / quotient
// Holds data only, so it carries no reset; the sequencer decides when
// its contents are meaningful.
module mdu_datapath
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] b_q, b_d;
  // Two guard bits: one for the multiply carry, one as the divide borrow sign.
  logic [XLEN+1:0] lhs, rhs, addsub;

  always_comb begin
    if (is_div) begin
      // Trial subtract of the divisor from the partial remainder shifted
      // left with the next dividend bit.
      lhs = {1'b0, hi_q, lo_q[XLEN-1]};
      rhs = ~{2'b00, b_q};
    end else begin
      lhs = {2'b00, hi_q};
      rhs = lo_q[0] ? {2'b00, b_q} : '0;
    end
    addsub = lhs + rhs + {{(XLEN+1){1'b0}}, is_div};

    hi_d = hi_q;
    lo_d = lo_q;
    b_d  = b_q;
    if (load) begin
      hi_d = '0;
      lo_d = a_in;
      b_d  = b_in;
    end else if (step) begin
      if (is_div) begin
        if (!addsub[XLEN+1]) begin
          hi_d = addsub[XLEN-1:0];
          lo_d = {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d = {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        // Shift the {carry, sum, multiplier} chain right by one.
        hi_d = addsub[XLEN:1];
        lo_d = {addsub[0], lo_q[XLEN-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    hi_q <= hi_d;
    lo_q <= lo_d;
    b_q  <= b_d;
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: RISC-V M-extension multiply/divide unit control.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   req_valid/ready   - request handshake from EX
//   funct3            - operation select (mdu_op_e)
//   op_a, op_b        - rs1 / rs2 operands
//   flush             - kill the in-flight operation
//   busy              - stall request to the hazard unit
//   res_valid, result - one-cycle result strobe and held result
// Build option: define MDU_EARLY_OUT_EN to finish divide-by-zero and
// signed-overflow requests directly from IDLE to DONE.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN = MDU_XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            res_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  mdu_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  mdu_op_e         op_q, op_d;
  logic            neg_q, neg_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] special_val_q, special_val_d;
  logic [XLEN-1:0] result_q, result_d;

  mdu_op_e         op_in;
  logic            accept;
  logic            a_neg, b_neg, b_zero, ovf, special_in, neg_in;
  logic [XLEN-1:0] a_abs, b_abs, special_val_in, fix_val;
  logic [XLEN-1:0] dp_hi, dp_lo;
  logic [2*XLEN-1:0] prod, prod_fix;

  assign op_in     = mdu_op_e'(funct3);
  assign req_ready = (state_q == IDLE) && !flush && !rst;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE) || accept;
  assign res_valid = (state_q == DONE);
  assign result    = result_q;

  // Operand conditioning and special-case detection on the request.
  always_comb begin
    a_neg  = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && op_a[XLEN-1];
    b_neg  = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && op_b[XLEN-1];
    a_abs  = a_neg ? -op_a : op_a;
    b_abs  = b_neg ? -op_b : op_b;
    b_zero = (op_b == '0);
    ovf    = (op_in inside {OP_DIV, OP_REM}) &&
             (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special_in = funct3[2] && (b_zero || ovf);
    // funct3[1] distinguishes REM/REMU from DIV/DIVU.
    if (b_zero) special_val_in = funct3[1] ? op_a : '1;
    else        special_val_in = funct3[1] ? '0 : op_a;
    // Remainder follows the dividend; everything else follows the sign product.
    neg_in = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  // Sign correction applied while in FIX.
  always_comb begin
    prod     = {dp_hi, dp_lo};
    prod_fix = neg_q ? -prod : prod;
    unique case (op_q)
      OP_MUL:                         fix_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:   fix_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:                fix_val = neg_q ? -dp_lo : dp_lo;
      default:                        fix_val = neg_q ? -dp_hi : dp_hi;
    endcase
    if (special_q) fix_val = special_val_q;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    neg_d         = neg_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    result_d      = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d          = op_in;
          neg_d         = neg_in;
          special_d     = special_in;
          special_val_d = special_val_in;
          cnt_d         = '0;
          state_d       = CALC;
`ifdef MDU_EARLY_OUT_EN
          if (special_in) begin
            state_d  = DONE;
            result_d = special_val_in;
          end
`else
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        state_d  = DONE;
        result_d = fix_val;
      end
      default: state_d = IDLE;
    endcase
    if (flush && (state_q != IDLE)) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      result_q  <= result_d;
    end
  end

  always_ff @(posedge clk) begin
    special_val_q <= special_val_d;
  end

  mdu_datapath #(.XLEN(XLEN)) u_datapath (
    .clk    (clk),
    .load   (accept),
    .step   (state_q == CALC),
    .is_div (op_q[2]),
    .a_in   (a_abs),
    .b_in   (b_abs),
    .hi     (dp_hi),
    .lo     (dp_lo)
  );

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 1 bit: the EX stage presents an M-extension operation.
REQ-005 The block SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-006 The block SHALL have port funct3, input, 3 bits: the operation (000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-007 The block SHALL have ports op_a and op_b, input, XLEN bits each: rs1 and rs2 values.
REQ-008 The block SHALL have port flush, input, 1 bit: the pipeline kills the in-flight operation.
REQ-009 The block SHALL have port busy, output, 1 bit: stall request to the hazard unit.
REQ-010 The block SHALL have port res_valid, output, 1 bit: result-valid pulse.
REQ-011 The block SHALL have port result, output, XLEN bits: the operation result.

Function
REQ-012 The block SHALL implement FSM states IDLE, CALC, FIX and DONE.
REQ-013 req_ready SHALL equal (state==IDLE) && !flush && !rst; acceptance SHALL occur on a rising edge where req_valid && req_ready.
REQ-014 On acceptance the block SHALL latch funct3, op_a and op_b, and SHALL take the absolute values of signed operands (MULH: both; MULHSU: op_a only; DIV/REM: both).
REQ-015 Transitions: IDLE->CALC on acceptance; CALC SHALL run exactly XLEN cycles (one shift-add or restoring-subtract step per cycle, via an iteration counter 0..XLEN-1); CALC->FIX after the last step; FIX->DONE; DONE->IDLE.
REQ-016 FIX SHALL apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
REQ-017 res_valid SHALL be 1 only in DONE, i.e. XLEN+2 cycles after the acceptance edge (34 for XLEN=32).
REQ-018 result SHALL update only on entry to DONE and SHALL hold until the next DONE entry.
REQ-019 MUL SHALL return the low XLEN bits; MULH, MULHSU and MULHU SHALL return the high XLEN bits of the 2*XLEN product.
REQ-020 Divide by zero: DIV and DIVU SHALL return all ones; REM and REMU SHALL return op_a.
REQ-021 Signed overflow (op_a = most-negative, op_b = -1): DIV SHALL return op_a; REM SHALL return 0.
REQ-022 busy SHALL be 1 in every state except IDLE, and in IDLE on the acceptance cycle; EX SHALL hold operands stable while busy is set.
REQ-023 A flush in any non-IDLE state SHALL force IDLE on the next edge with no res_valid pulse; result SHALL be left unchanged.
REQ-024 A flush in IDLE coincident with req_valid SHALL block acceptance.
REQ-025 req_valid SHALL be ignored while state!=IDLE.

Reset
REQ-026 On rst assertion, without waiting for clk, the block SHALL set state=IDLE, counter=0, result=0, res_valid=0 and busy=0.
REQ-027 Reset mid-operation SHALL discard the operation with no res_valid pulse.
REQ-028 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-029 With MDU_EARLY_OUT_EN defined, divide-by-zero and signed-overflow requests SHALL go IDLE->DONE directly, giving res_valid one cycle after acceptance with the REQ-020/021 values.
REQ-030 Without MDU_EARLY_OUT_EN, every operation SHALL take exactly XLEN+2 cycles and SHALL still produce the REQ-020/021 values.

Structure
REQ-031 Package mdu_pkg SHALL hold the mdu_op_e enum (funct3 encodings), the mdu_state_e enum and the XLEN default localparam.
REQ-032 Sub-module mdu_datapath SHALL hold the accumulator, shift registers and adder/subtractor; mdu_sequencer SHALL hold the FSM, counter, handshake and sign/special-case logic.

Verification
REQ-033 MUL 7 * 0xFFFFFFFD SHALL give result 0xFFFFFFEB, with res_valid exactly 34 cycles after acceptance.
REQ-034 MULHU 0xFFFFFFFF * 0xFFFFFFFF SHALL give 0xFFFFFFFE; MULH of the same operands SHALL give 0x00000000.
REQ-035 DIV -7/2 SHALL give 0xFFFFFFFD; REM -7/2 SHALL give 0xFFFFFFFF; DIVU 100/7 SHALL give 14.
REQ-036 DIVU 5/0 SHALL give 0xFFFFFFFF and REM 5/0 SHALL give 5; latency SHALL be 1 cycle with MDU_EARLY_OUT_EN and 34 without.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF SHALL give 0x80000000, and REM of the same operands SHALL give 0.
REQ-038 A flush on CALC cycle 10 SHALL produce no res_valid; req_ready SHALL be 1 the next cycle; a back-to-back request SHALL then be accepted and complete correctly.
